reg_bank_ctrl: RTL and testbench

Parametrised control/status register bank for the front-end digital core. It replaces fixed per-register read/write helper functions with a clocked block that has a request/response bus port, four access types per register (RW, RO, W1C sticky flag, self-clearing strobe), per-register field masks, and a key-based write lock with timeout. It sits between the configuration bus decoder and the datapath blocks that consume the register outputs.

---
 rtl/reg_bank_ctrl.sv | 166 ++++++++++++++++
 tb/tb_reg_bank_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_ctrl.sv
// Control/status register bank with a bus port, per-register access kinds and field masks, and a
// key-based write lock that times out. One request per cycle; every response comes one cycle later.
module reg_bank_ctrl #(
   parameter int                        ADDR_W        = 4,
   parameter int                        DATA_W        = 32,
   parameter int                        N_REGS        = 10,
   parameter logic [N_REGS-1:0]         RO_MASK       = 10'b10_0100_0000,
   parameter logic [N_REGS-1:0]         W1C_MASK      = 10'b00_0100_0000,
   parameter logic [N_REGS-1:0]         STROBE_MASK   = 10'b00_1000_0000,
   parameter logic [N_REGS*DATA_W-1:0]  FIELD_MASK    = {32'hFFFF_FFFF, 32'h0001_FFFF, {8{32'hFFFF_FFFF}}},
   parameter logic [N_REGS*DATA_W-1:0]  RESET_VALUES  = {32'h0000_0000, 32'h0000_FFFF, {8{32'h0000_0000}}},
   parameter int                        KEY_ADDR      = 9,
   parameter logic [DATA_W-1:0]         UNLOCK_KEY    = 32'hBADE_FACE,
   parameter int                        UNLOCK_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       bus_valid,
   input  logic                       bus_write,
   input  logic [ADDR_W-1:0]          bus_addr,
   input  logic [DATA_W-1:0]          bus_wdata,
   output logic                       rsp_valid,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_error,
   input  logic [N_REGS*DATA_W-1:0]   hw_ro_value,
   input  logic [N_REGS*DATA_W-1:0]   hw_set,
   output logic [N_REGS*DATA_W-1:0]   reg_out,
   output logic [N_REGS-1:0]          strobe_out,
   output logic                       locked
);

   localparam int                 CNT_W     = $clog2(UNLOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(UNLOCK_CYCLES - 1);
   localparam logic [ADDR_W-1:0]  KEY_IDX   = ADDR_W'(KEY_ADDR);
   localparam logic [ADDR_W:0]    REG_COUNT = (ADDR_W + 1)'(N_REGS);
   // A register marked both RO and W1C is a hardware-set flag: it stores and accepts clears.
   localparam logic [N_REGS-1:0]  PLAIN_RO  = RO_MASK & ~W1C_MASK;

   function automatic logic [N_REGS*DATA_W-1:0] resetImage();
      logic [N_REGS*DATA_W-1:0] img;
      img = RESET_VALUES & FIELD_MASK;
      for (int i = 0; i < N_REGS; i++) begin
         if (PLAIN_RO[i]) img[i*DATA_W +: DATA_W] = '0;
      end
      return img;
   endfunction

   localparam logic [N_REGS*DATA_W-1:0] RESET_IMAGE = resetImage();

   typedef enum logic {LOCKED, UNLOCKED} lockState_e;

   lockState_e                stateQ, stateNext;
   logic [CNT_W-1:0]          cntQ, cntNext;
   logic [N_REGS*DATA_W-1:0]  regQ, regNext;
   logic [N_REGS-1:0]         strobeQ, strobeNext;
   logic [N_REGS-1:0]         hitVec, wrEn;
   logic                      inRange, isKey, roHit, wrReq, keyMatch, wrAccept, errNext;
   logic [DATA_W-1:0]         rdataNext;
   logic                      unusedBits;

   // Input bits that only some register kinds consume.
   assign unusedBits = ^{hw_set, hw_ro_value};

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      inRange  = {1'b0, bus_addr} < REG_COUNT;
      isKey    = bus_addr == KEY_IDX;
      wrReq    = bus_valid && bus_write;
      keyMatch = bus_wdata == UNLOCK_KEY;
      hitVec   = '0;
      for (int i = 0; i < N_REGS; i++) begin
         hitVec[i] = bus_valid && (bus_addr == ADDR_W'(i));
      end
      roHit    = |(hitVec & PLAIN_RO);
      wrAccept = wrReq && inRange && !isKey && !roHit && (stateQ == UNLOCKED);
      wrEn     = wrAccept ? hitVec : '0;

      errNext = 1'b0;
      if (bus_valid) begin
         if (!inRange)       errNext = 1'b1;
         else if (bus_write) begin
            if (isKey) errNext = (stateQ == LOCKED) && !keyMatch;
            else       errNext = roHit || (stateQ == LOCKED);
         end
      end
   end

   // Lock FSM: a key write always takes priority over the running timeout.
   always_comb begin
      stateNext = stateQ;
      cntNext   = cntQ;
      if (stateQ == UNLOCKED) begin
         if (cntQ == '0) stateNext = LOCKED;
         else            cntNext   = cntQ - CNT_W'(1);
      end
      if (wrReq && isKey) begin
         if (keyMatch) begin
            stateNext = UNLOCKED;
            cntNext   = CNT_LOAD;
         end else begin
            stateNext = LOCKED;
            cntNext   = '0;
         end
      end
   end

   always_comb begin
      regNext    = regQ;
      strobeNext = '0;
      for (int i = 0; i < N_REGS; i++) begin
         if (PLAIN_RO[i]) begin
            regNext[i*DATA_W +: DATA_W] = '0;
         end else if (W1C_MASK[i]) begin
            // Set is OR-ed after the clear so a simultaneous hardware set wins.
            regNext[i*DATA_W +: DATA_W] =
               ((regQ[i*DATA_W +: DATA_W] & ~(wrEn[i] ? bus_wdata : '0)) | hw_set[i*DATA_W +: DATA_W])
               & FIELD_MASK[i*DATA_W +: DATA_W];
         end else if (STROBE_MASK[i]) begin
            regNext[i*DATA_W +: DATA_W] = wrEn[i] ? (bus_wdata & FIELD_MASK[i*DATA_W +: DATA_W])
                                                  : RESET_IMAGE[i*DATA_W +: DATA_W];
            strobeNext[i] = wrEn[i];
         end else if (wrEn[i]) begin
            regNext[i*DATA_W +: DATA_W] = bus_wdata & FIELD_MASK[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rdataNext = '0;
      if (bus_valid && !bus_write) begin
         for (int i = 0; i < N_REGS; i++) begin
            if (hitVec[i]) begin
               rdataNext = (PLAIN_RO[i] ? hw_ro_value[i*DATA_W +: DATA_W] : regQ[i*DATA_W +: DATA_W])
                           & FIELD_MASK[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the register bank is a handful of flops, not a RAM, so it is reset like any other state.
         stateQ    <= LOCKED;
         cntQ      <= '0;
         regQ      <= RESET_IMAGE;
         strobeQ   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else begin
         stateQ    <= stateNext;
         cntQ      <= cntNext;
         regQ      <= regNext;
         strobeQ   <= strobeNext;
         rsp_valid <= bus_valid;
         rsp_rdata <= errNext ? '0 : rdataNext;
         rsp_error <= errNext;
      end
   end

   assign reg_out    = regQ;
   assign strobe_out = strobeQ;
   assign locked     = (stateQ == LOCKED);

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Self-checking bench for reg_bank_ctrl: directed scenarios plus a randomized run against a
// cycle-level reference model that tracks register contents and the count of remaining unlocked cycles.
module tb_reg_bank_ctrl;

   localparam int          N   = 10;
   localparam logic [31:0] KEY = 32'hBADE_FACE;

   logic         clk = 1'b0;
   logic         reset;
   logic         bus_valid, bus_write;
   logic [3:0]   bus_addr;
   logic [31:0]  bus_wdata;
   logic         rsp_valid;
   logic [31:0]  rsp_rdata;
   logic         rsp_error;
   logic [319:0] hw_ro_value, hw_set, reg_out;
   logic [9:0]   strobe_out;
   logic         locked;

   int checks = 0;
   int errors = 0;

   // Reference model: visible register values and number of future cycles in which writes are accepted.
   logic [31:0] mReg [N];
   int          unlockLeft;
   logic        expValid, expErr;
   logic [31:0] expRdata;
   logic [9:0]  expStrobe;

   reg_bank_ctrl dut (
      .clk(clk), .reset(reset),
      .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .hw_ro_value(hw_ro_value), .hw_set(hw_set),
      .reg_out(reg_out), .strobe_out(strobe_out), .locked(locked)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fieldMask(int i);
      return (i == 8) ? 32'h0001_FFFF : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] resetVal(int i);
      return (i == 8) ? 32'h0000_FFFF : 32'h0;
   endfunction

   function automatic logic [31:0] slice(logic [319:0] v, int i);
      return v[i*32 +: 32];
   endfunction

   function automatic logic [319:0] put(int i, logic [31:0] x);
      logic [319:0] v;
      v = '0;
      v[i*32 +: 32] = x;
      return v;
   endfunction

   function automatic logic [319:0] modelImage();
      logic [319:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i*32 +: 32] = (i == 9) ? 32'h0 : mReg[i];
      return v;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < N; i++) mReg[i] = (i == 9) ? 32'h0 : resetVal(i);
      unlockLeft = 0;
   endtask

   // Presents one request for one clock, predicts the response, and advances the model.
   task automatic doCycle(input logic v, input logic w, input logic [3:0] a,
                          input logic [31:0] d, input logic [319:0] hs);
      int          ai;
      bit          lockedNow, accept;
      logic [31:0] nxt [N];
      ai        = int'(a);
      lockedNow = (unlockLeft == 0);
      accept    = 0;
      expValid  = v;
      expErr    = 1'b0;
      expRdata  = 32'h0;
      expStrobe = '0;
      if (v) begin
         if (ai >= N)        expErr = 1'b1;
         else if (!w)        expRdata = (ai == 9) ? (slice(hw_ro_value, 9) & fieldMask(9)) : mReg[ai];
         else if (ai == 9)   expErr = lockedNow && (d != KEY);
         else if (lockedNow) expErr = 1'b1;
         else                accept = 1;
      end
      for (int i = 0; i < N; i++) nxt[i] = mReg[i];
      nxt[6] = (mReg[6] & ~((accept && ai == 6) ? d : 32'h0)) | slice(hs, 6);
      nxt[7] = (accept && ai == 7) ? d : resetVal(7);
      expStrobe[7] = accept && (ai == 7);
      if (accept && ai != 6 && ai != 7) nxt[ai] = d & fieldMask(ai);

      bus_valid = v;
      bus_write = w;
      bus_addr  = a;
      bus_wdata = d;
      hw_set    = hs;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) mReg[i] = nxt[i];
      if (v && w && ai == 9) unlockLeft = (d == KEY) ? 16 : 0;
      else if (unlockLeft > 0) unlockLeft--;
      bus_valid = 1'b0;
      hw_set    = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) doCycle(1'b0, 1'b0, 4'd0, 32'h0, '0);
   endtask

   // Holds reset for two edges with a request and hardware set pulses present; both must be dropped.
   task automatic applyReset();
      reset     = 1'b1;
      bus_valid = 1'b1;
      bus_write = 1'b1;
      bus_addr  = 4'd0;
      bus_wdata = 32'h3;
      hw_set    = '1;
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b0;
      bus_valid = 1'b0;
      hw_set    = '0;
      modelReset();
   endtask

   task automatic test_reset();
      logic [319:0] img;
      applyReset();
      img = '0;
      img[8*32 +: 32] = 32'h0000_FFFF;
      checks++; if (reg_out !== img) begin errors++; $display("FAIL reset_reg_out: got %h expected %h", reg_out, img); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp: got err=%b rdata=%h expected 0/0", rsp_error, rsp_rdata); end
      checks++; if (locked !== 1'b1 || strobe_out !== 10'h0) begin errors++; $display("FAIL reset_lock_strobe: got locked=%b strobe=%h expected 1/000", locked, strobe_out); end
      hw_ro_value = put(9, KEY);
      doCycle(1'b1, 1'b0, 4'd9, 32'h0, '0);
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== KEY || rsp_error !== 1'b0) begin errors++; $display("FAIL read_key: got v=%b rdata=%h err=%b expected 1/%h/0", rsp_valid, rsp_rdata, rsp_error, KEY); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL read_key_locked: got %b expected 1", locked); end
   endtask

   task automatic test_lock();
      doCycle(1'b1, 1'b1, 4'd0, 32'h3, '0);
      checks++; if (rsp_error !== 1'b1 || slice(reg_out, 0) !== 32'h0) begin errors++; $display("FAIL locked_write: got err=%b reg0=%h expected 1/0", rsp_error, slice(reg_out, 0)); end
      doCycle(1'b1, 1'b1, 4'd9, KEY, '0);
      checks++; if (rsp_error !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL unlock: got err=%b locked=%b expected 0/0", rsp_error, locked); end
      doCycle(1'b1, 1'b1, 4'd0, 32'h3, '0);
      checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL unlocked_write: got err=%b expected 0", rsp_error); end
      doCycle(1'b1, 1'b0, 4'd0, 32'h0, '0);
      checks++; if (rsp_rdata !== 32'h3 || rsp_error !== 1'b0) begin errors++; $display("FAIL read_back: got %h err=%b expected 00000003/0", rsp_rdata, rsp_error); end
   endtask

   task automatic test_timeout();
      doCycle(1'b1, 1'b1, 4'd9, KEY, '0);
      idle(16);
      doCycle(1'b1, 1'b1, 4'd4, 32'h55, '0);
      checks++; if (rsp_error !== 1'b1 || locked !== 1'b1 || slice(reg_out, 4) !== 32'h0) begin errors++; $display("FAIL timeout_17th: got err=%b locked=%b reg4=%h expected 1/1/0", rsp_error, locked, slice(reg_out, 4)); end
      doCycle(1'b1, 1'b1, 4'd9, KEY, '0);
      idle(15);
      doCycle(1'b1, 1'b1, 4'd4, 32'hA5, '0);
      checks++; if (rsp_error !== 1'b0 || slice(reg_out, 4) !== 32'hA5 || locked !== 1'b1) begin errors++; $display("FAIL timeout_16th: got err=%b reg4=%h locked=%b expected 0/a5/1", rsp_error, slice(reg_out, 4), locked); end
      doCycle(1'b1, 1'b1, 4'd15, 32'h1, '0);
      checks++; if (rsp_error !== 1'b1) begin errors++; $display("FAIL range_write: got err=%b expected 1", rsp_error); end
      doCycle(1'b1, 1'b0, 4'd12, 32'h0, '0);
      checks++; if (rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL range_read: got err=%b rdata=%h expected 1/0", rsp_error, rsp_rdata); end
      doCycle(1'b1, 1'b1, 4'd9, 32'h1234_5678, '0);
      checks++; if (rsp_error !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL wrong_key: got err=%b locked=%b expected 1/1", rsp_error, locked); end
      doCycle(1'b1, 1'b1, 4'd9, KEY, '0);
      doCycle(1'b1, 1'b1, 4'd9, 32'h0, '0);
      checks++; if (rsp_error !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL relock: got err=%b locked=%b expected 0/1", rsp_error, locked); end
      doCycle(1'b1, 1'b1, 4'd9, KEY, '0);
      idle(10);
      doCycle(1'b1, 1'b1, 4'd9, KEY, '0);
      idle(15);
      doCycle(1'b1, 1'b1, 4'd1, 32'h77, '0);
      checks++; if (rsp_error !== 1'b0 || slice(reg_out, 1) !== 32'h77) begin errors++; $display("FAIL reload: got err=%b reg1=%h expected 0/77", rsp_error, slice(reg_out, 1)); end
   endtask

   task automatic test_w1c();
      doCycle(1'b1, 1'b1, 4'd9, KEY, '0);
      doCycle(1'b0, 1'b0, 4'd0, 32'h0, put(6, 32'h1));
      checks++; if (slice(reg_out, 6) !== 32'h1) begin errors++; $display("FAIL w1c_set: got %h expected 00000001", slice(reg_out, 6)); end
      doCycle(1'b1, 1'b1, 4'd6, 32'h1, put(6, 32'h1));
      checks++; if (rsp_error !== 1'b0 || slice(reg_out, 6) !== 32'h1) begin errors++; $display("FAIL w1c_set_wins: got err=%b reg6=%h expected 0/1", rsp_error, slice(reg_out, 6)); end
      doCycle(1'b1, 1'b1, 4'd6, 32'h1, '0);
      doCycle(1'b1, 1'b0, 4'd6, 32'h0, '0);
      checks++; if (rsp_rdata !== 32'h0 || slice(reg_out, 6) !== 32'h0) begin errors++; $display("FAIL w1c_clear: got rdata=%h reg6=%h expected 0/0", rsp_rdata, slice(reg_out, 6)); end
   endtask

   task automatic test_strobe();
      doCycle(1'b1, 1'b1, 4'd9, KEY, '0);
      doCycle(1'b1, 1'b1, 4'd7, 32'h1, '0);
      checks++; if (strobe_out !== 10'h080 || slice(reg_out, 7) !== 32'h1) begin errors++; $display("FAIL strobe_pulse: got strobe=%h reg7=%h expected 080/1", strobe_out, slice(reg_out, 7)); end
      idle(1);
      checks++; if (strobe_out !== 10'h000 || slice(reg_out, 7) !== 32'h0) begin errors++; $display("FAIL strobe_clear: got strobe=%h reg7=%h expected 000/0", strobe_out, slice(reg_out, 7)); end
   endtask

   task automatic test_back_to_back();
      doCycle(1'b1, 1'b1, 4'd9, KEY, '0);
      doCycle(1'b1, 1'b1, 4'd3, 32'h1234, '0);
      doCycle(1'b1, 1'b0, 4'd3, 32'h0, '0);
      checks++; if (rsp_rdata !== 32'h1234) begin errors++; $display("FAIL b2b_read: got %h expected 00001234", rsp_rdata); end
      doCycle(1'b1, 1'b1, 4'd5, 32'hAAAA, '0);
      doCycle(1'b1, 1'b1, 4'd5, 32'h5555, '0);
      doCycle(1'b1, 1'b0, 4'd5, 32'h0, '0);
      checks++; if (rsp_rdata !== 32'h5555) begin errors++; $display("FAIL b2b_overwrite: got %h expected 00005555", rsp_rdata); end
   endtask

   task automatic test_mask();
      doCycle(1'b1, 1'b1, 4'd9, KEY, '0);
      doCycle(1'b1, 1'b1, 4'd8, 32'hFFFF_FFFF, '0);
      doCycle(1'b1, 1'b0, 4'd8, 32'h0, '0);
      checks++; if (rsp_rdata !== 32'h0001_FFFF) begin errors++; $display("FAIL field_mask: got %h expected 0001ffff", rsp_rdata); end
      doCycle(1'b1, 1'b1, 4'd9, KEY, '0);
      idle(3);
      applyReset();
      checks++; if (locked !== 1'b1 || slice(reg_out, 8) !== 32'h0000_FFFF) begin errors++; $display("FAIL reset_mid_unlock: got locked=%b reg8=%h expected 1/0000ffff", locked, slice(reg_out, 8)); end
   endtask

   task automatic test_random();
      logic         v, w;
      logic [3:0]   a;
      logic [31:0]  d;
      logic [319:0] hs;
      applyReset();
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            applyReset();
            continue;
         end
         for (int i = 0; i < N; i++) hw_ro_value[i*32 +: 32] = $urandom;
         hs = '0;
         for (int i = 0; i < N; i++) hs[i*32 +: 32] = (i == 6) ? ($urandom & $urandom & $urandom) : $urandom;
         v = ($urandom_range(0, 5) != 0);
         w = $urandom_range(0, 1) == 1;
         a = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         d = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            v = 1'b1;
            w = 1'b1;
            a = 4'd9;
            d = ($urandom_range(0, 3) == 0) ? $urandom : KEY;
         end
         doCycle(v, w, a, d, hs);
         checks++;
         if (rsp_valid !== expValid || rsp_error !== expErr || rsp_rdata !== expRdata) begin
            errors++;
            $display("FAIL rand_rsp[%0d]: got v=%b err=%b rdata=%h expected %b/%b/%h", n, rsp_valid, rsp_error, rsp_rdata, expValid, expErr, expRdata);
         end
         checks++;
         if (reg_out !== modelImage()) begin
            errors++;
            $display("FAIL rand_reg_out[%0d]: got %h expected %h", n, reg_out, modelImage());
         end
         checks++;
         if (strobe_out !== expStrobe || locked !== (unlockLeft == 0)) begin
            errors++;
            $display("FAIL rand_strobe_lock[%0d]: got strobe=%h locked=%b expected %h/%b", n, strobe_out, locked, expStrobe, unlockLeft == 0);
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      bus_valid   = 1'b0;
      bus_write   = 1'b0;
      bus_addr    = 4'd0;
      bus_wdata   = 32'h0;
      hw_ro_value = '0;
      hw_set      = '0;
      modelReset();
      test_reset();
      test_lock();
      test_timeout();
      test_w1c();
      test_strobe();
      test_back_to_back();
      test_mask();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
